// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, width helpers and command constants for the APB master bridge
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;
    localparam logic RW_READ = 1'b1;
    function automatic int sel_w(input int num_slaves);
        return $clog2(num_slaves);
    endfunction
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/apb_slave_decoder.sv
// apb_slave_decoder: maps the top address bits to a slave index and one-hot select
// Ports: i_addr (address) -> o_idx (slave index), o_sel (one-hot, 0 on error), o_decode_err (index out of range)
module apb_slave_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int NUM_SLAVES = 2
) (
    input  logic [ADDR_W-1:0]           i_addr,
    output logic [sel_w(NUM_SLAVES)-1:0] o_idx,
    output logic [NUM_SLAVES-1:0]       o_sel,
    output logic                        o_decode_err
);
    localparam int SW = sel_w(NUM_SLAVES);
    assign o_idx        = i_addr[ADDR_W-1 -: SW];
    assign o_decode_err = 32'(o_idx) >= NUM_SLAVES;
    assign o_sel        = o_decode_err ? '0 : {{(NUM_SLAVES-1){1'b0}}, 1'b1} << o_idx;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command user interface to an APB4 bus with address-decoded PSEL, waits, PSTRB, decode error and PREADY timeout
// Ports: PCLK/PRESETn; command side transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data, apb_write_strb,
//        cmd_ready, rsp_valid, apb_read_data_out, PSLVERR; bus side PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE, s_prdata, s_pready, s_pslverr
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         transfer,
    input  logic                         READ_WRITE,
    input  logic [ADDR_W-1:0]            apb_write_paddr,
    input  logic [ADDR_W-1:0]            apb_read_paddr,
    input  logic [DATA_W-1:0]            apb_write_data,
    input  logic [strb_w(DATA_W)-1:0]    apb_write_strb,
    output logic                         cmd_ready,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            apb_read_data_out,
    output logic                         PSLVERR,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [strb_w(DATA_W)-1:0]    PSTRB,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]        s_pready,
    input  logic [NUM_SLAVES-1:0]        s_pslverr
);
    localparam int SW   = sel_w(NUM_SLAVES);
    localparam int TO_W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_idx, w_idx;
    logic [NUM_SLAVES-1:0] w_sel;
    logic                w_decerr, w_rdy, w_to, w_done, w_err, w_load, w_read;
    logic [ADDR_W-1:0]   w_addr;
    logic [TO_W-1:0]     r_cnt;
    assign w_read    = READ_WRITE == RW_READ;
    assign w_addr    = w_read ? apb_read_paddr : apb_write_paddr;
    assign w_rdy     = s_pready[r_idx];
    assign w_to      = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !w_rdy;
    assign cmd_ready = (r_state == IDLE) || (r_state == ACCESS && w_rdy);
    assign w_load    = transfer && cmd_ready;
    apb_slave_decoder #(.ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES)) u_dec (
        .i_addr       (w_addr),
        .o_idx        (w_idx),
        .o_sel        (w_sel),
        .o_decode_err (w_decerr)
    );
    // DECERR spans two cycles (r_cnt 0 then 1) so a decode error keeps the
    // same 2-cycle accept-to-response latency as a zero-wait transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                w_done      = w_rdy || w_to;
                w_err       = w_rdy ? s_pslverr[r_idx] : 1'b1;
                w_state_nxt = w_done ? IDLE : ACCESS;
            end
            DECERR: begin
                w_done      = r_cnt[0];
                w_err       = 1'b1;
                w_state_nxt = r_cnt[0] ? IDLE : DECERR;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_load) w_state_nxt = w_decerr ? DECERR : SETUP;
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state           <= IDLE;
            r_idx             <= '0;
            r_cnt             <= '0;
            PADDR             <= '0;
            PWRITE            <= 1'b0;
            PWDATA            <= '0;
            PSTRB             <= '0;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            rsp_valid         <= 1'b0;
            PSLVERR           <= 1'b0;
            apb_read_data_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= (w_state_nxt == r_state && r_state != IDLE) ? r_cnt + 1'b1 : '0;
            rsp_valid <= w_done;
            PENABLE   <= w_state_nxt == ACCESS;
            PSEL      <= w_load ? w_sel : (w_done ? '0 : PSEL);
            if (w_done) begin
                PSLVERR <= w_err;
                if (!PWRITE) apb_read_data_out <= w_err ? '0 : s_prdata[r_idx*DATA_W +: DATA_W];
            end
            if (w_load) begin
                r_idx  <= w_idx;
                PADDR  <= w_addr;
                PWRITE <= !w_read;
                PWDATA <= w_read ? '0 : apb_write_data;
                PSTRB  <= w_read ? '0 : apb_write_strb;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed table-driven bench for the APB master bridge plus multi-cycle corner sequences
module tb_apb_master_bridge;
    logic        clk = 1'b0;
    logic        PRESETn = 1'b0;
    logic        a_transfer = 1'b0, b_transfer = 1'b0, rw = 1'b0;
    logic [8:0]  wr_addr = '0, rd_addr = '0;
    logic [7:0]  wdata = '0;
    logic        strb = 1'b0;
    logic        a_cmd_ready, a_rsp, a_err, a_pwrite, a_penable;
    logic [7:0]  a_rdata, a_pwdata;
    logic [8:0]  a_paddr;
    logic        a_pstrb;
    logic [1:0]  a_psel;
    logic [15:0] a_prdata = '0;
    logic [1:0]  a_pready = '0, a_pslverr = '0;
    logic        b_cmd_ready, b_rsp, b_err, b_pwrite, b_penable, b_pstrb;
    logic [7:0]  b_rdata, b_pwdata;
    logic [8:0]  b_paddr;
    logic [2:0]  b_psel;
    logic [23:0] b_prdata = '0;
    logic [2:0]  b_pready = '0, b_pslverr = '0;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT_CYCLES(4)) dut_a (
        .PCLK(clk), .PRESETn(PRESETn), .transfer(a_transfer), .READ_WRITE(rw),
        .apb_write_paddr(wr_addr), .apb_read_paddr(rd_addr), .apb_write_data(wdata), .apb_write_strb(strb),
        .cmd_ready(a_cmd_ready), .rsp_valid(a_rsp), .apb_read_data_out(a_rdata), .PSLVERR(a_err),
        .PADDR(a_paddr), .PWRITE(a_pwrite), .PWDATA(a_pwdata), .PSTRB(a_pstrb), .PSEL(a_psel), .PENABLE(a_penable),
        .s_prdata(a_prdata), .s_pready(a_pready), .s_pslverr(a_pslverr)
    );

    apb_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) dut_b (
        .PCLK(clk), .PRESETn(PRESETn), .transfer(b_transfer), .READ_WRITE(rw),
        .apb_write_paddr(wr_addr), .apb_read_paddr(rd_addr), .apb_write_data(wdata), .apb_write_strb(strb),
        .cmd_ready(b_cmd_ready), .rsp_valid(b_rsp), .apb_read_data_out(b_rdata), .PSLVERR(b_err),
        .PADDR(b_paddr), .PWRITE(b_pwrite), .PWDATA(b_pwdata), .PSTRB(b_pstrb), .PSEL(b_psel), .PENABLE(b_penable),
        .s_prdata(b_prdata), .s_pready(b_pready), .s_pslverr(b_pslverr)
    );

    typedef struct {
        bit         rw;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] prdata;
        bit         strb;
        int         waits;
        bit         slverr;
        logic [1:0] psel;
        bit         err;
        logic [7:0] rdata;
        int         lat;
        int         en;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int  k;
        int  en;
        bit  seen;
        bit  pr;
        int  idx;
        idx = int'(v.addr[8]);
        @(negedge clk);
        a_transfer = 1'b1;
        rw         = v.rw;
        rd_addr    = v.rw ? v.addr : ~v.addr;
        wr_addr    = v.rw ? ~v.addr : v.addr;
        wdata      = v.wdata;
        strb       = v.strb;
        a_prdata   = idx == 1 ? {v.prdata, ~v.prdata} : {~v.prdata, v.prdata};
        a_pslverr  = idx == 1 ? {v.slverr, !v.slverr} : {!v.slverr, v.slverr};
        a_pready   = idx == 1 ? 2'b01 : 2'b10;
        chk("cmd_ready_idle", a_cmd_ready, 1);
        @(negedge clk);
        a_transfer = 1'b0;
        chk("setup_psel", a_psel, v.psel);
        chk("setup_penable", a_penable, 0);
        chk("setup_paddr", a_paddr, v.addr);
        chk("setup_pwrite", a_pwrite, !v.rw);
        chk("setup_pwdata", a_pwdata, v.rw ? 8'h00 : v.wdata);
        chk("setup_pstrb", a_pstrb, v.rw ? 1'b0 : v.strb);
        k = 0;
        en = 0;
        seen = 0;
        while (!seen && k < 40) begin
            if (a_penable) en++;
            if (a_rsp) seen = 1;
            else begin
                pr = k >= 1 + v.waits;
                a_pready = idx == 1 ? {pr, !pr} : {!pr, pr};
                @(negedge clk);
                k++;
            end
        end
        chk("latency", k, v.lat);
        chk("penable_cycles", en, v.en);
        chk("pslverr", a_err, v.err);
        chk("read_data", a_rdata, v.rdata);
        chk("psel_after", a_psel, 0);
        a_pready = '0;
        @(negedge clk);
        chk("rsp_pulse_end", a_rsp, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 9'h005, 8'hA5, 8'h00, 1, 0,  0, 2'b01, 0, 8'h00, 2, 1};
        vecs[1] = '{1, 9'h105, 8'h00, 8'h3C, 1, 3,  0, 2'b10, 0, 8'h3C, 5, 4};
        vecs[2] = '{0, 9'h1F0, 8'h5A, 8'h99, 0, 1,  1, 2'b10, 1, 8'h3C, 3, 2};
        vecs[3] = '{1, 9'h0AA, 8'h00, 8'h77, 1, 2,  1, 2'b01, 1, 8'h00, 4, 3};
        vecs[4] = '{1, 9'h033, 8'h00, 8'hC3, 0, 0,  0, 2'b01, 0, 8'hC3, 2, 1};
        vecs[5] = '{1, 9'h100, 8'h00, 8'hEE, 1, 99, 0, 2'b10, 1, 8'h00, 5, 4};
        vecs[6] = '{0, 9'h1FF, 8'h3E, 8'h00, 1, 3,  0, 2'b10, 0, 8'h00, 5, 4};
        repeat (3) @(negedge clk);
        chk("rst_psel", a_psel, 0);
        chk("rst_penable", a_penable, 0);
        chk("rst_rsp", a_rsp, 0);
        chk("rst_pslverr", a_err, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_paddr", a_paddr, 0);
        chk("rst_pwdata_pstrb_pwrite", {a_pwdata, a_pstrb, a_pwrite}, 0);
        PRESETn = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        @(negedge clk);
        a_prdata  = {8'h22, 8'h11};
        a_pslverr = '0;
        a_pready  = '1;
        a_transfer = 1'b1;
        rw = 1'b1;
        rd_addr = 9'h011;
        wr_addr = 9'h1EE;
        @(negedge clk);
        chk("b2b_psel0", a_psel, 2'b01);
        rd_addr = 9'h122;
        @(negedge clk);
        chk("b2b_access0", a_penable, 1);
        chk("b2b_cmd_ready", a_cmd_ready, 1);
        @(negedge clk);
        chk("b2b_rsp0", a_rsp, 1);
        chk("b2b_psel1", a_psel, 2'b10);
        chk("b2b_setup1", a_penable, 0);
        chk("b2b_paddr1", a_paddr, 9'h122);
        chk("b2b_rdata0", a_rdata, 8'h11);
        a_transfer = 1'b0;
        @(negedge clk);
        chk("b2b_gap", a_rsp, 0);
        chk("b2b_access1", a_penable, 1);
        @(negedge clk);
        chk("b2b_rsp1", a_rsp, 1);
        chk("b2b_rdata1", a_rdata, 8'h22);
        chk("b2b_psel_done", a_psel, 0);
        a_pready = '0;

        @(negedge clk);
        a_transfer = 1'b1;
        rd_addr = 9'h005;
        @(negedge clk);
        a_transfer = 1'b0;
        @(negedge clk);
        chk("rstmid_access", a_penable, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rstmid_psel", a_psel, 0);
        chk("rstmid_penable", a_penable, 0);
        chk("rstmid_rdata", a_rdata, 0);
        a_pready = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_no_rsp", a_rsp, 0);
        end
        PRESETn = 1'b1;
        a_pready = '0;
        run_vec(vecs[4]);

        @(negedge clk);
        b_prdata  = {8'h5C, 8'hA1, 8'hA2};
        b_pslverr = 3'b011;
        b_pready  = 3'b100;
        b_transfer = 1'b1;
        rw = 1'b1;
        rd_addr = 9'h140;
        @(negedge clk);
        b_transfer = 1'b0;
        chk("b_psel_slave2", b_psel, 3'b100);
        @(negedge clk);
        @(negedge clk);
        chk("b_rsp_slave2", b_rsp, 1);
        chk("b_err_slave2", b_err, 0);
        chk("b_rdata_slave2", b_rdata, 8'h5C);
        @(negedge clk);
        b_pready = '1;
        b_transfer = 1'b1;
        rd_addr = 9'h1C0;
        @(negedge clk);
        b_transfer = 1'b0;
        chk("decerr_psel", b_psel, 0);
        chk("decerr_penable", b_penable, 0);
        chk("decerr_rsp_early0", b_rsp, 0);
        @(negedge clk);
        chk("decerr_rsp_early1", b_rsp, 0);
        chk("decerr_psel_hold", b_psel, 0);
        @(negedge clk);
        chk("decerr_rsp", b_rsp, 1);
        chk("decerr_pslverr", b_err, 1);
        chk("decerr_rdata", b_rdata, 0);
        @(negedge clk);
        chk("decerr_idle", b_cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
